// File: rtl/count_display.sv
// count_display: samples the 7-bit count bus, converts it to BCD with a
// sequential shift-add-3 FSM, and scans a 3-digit common-anode 7-segment
// display with leading-zero blanking and a dash pattern for over-range values.
module count_display #(
   parameter int SCAN_DIV = 1000,  // clk cycles each digit stays lit (>= 2)
   parameter int MAX_VAL  = 100    // largest value shown numerically
) (
   input  logic       clk,
   input  logic       reset,        // asynchronous, active-low
   input  logic [6:0] number,
   output logic [6:0] seg,          // {g,f,e,d,c,b,a}, active-low
   output logic [2:0] an,           // active-low one-hot digit enables
   output logic       busy,
   output logic       err
);

   localparam int         DIV_W    = $clog2(SCAN_DIV);
   localparam logic [6:0] SEG_BLK  = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b0111111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } state_t;

   state_t state, state_n;

   logic [6:0]  cap;        // value under conversion, kept intact for the range check
   logic [6:0]  shreg;      // binary bits still to be shifted into the BCD accumulator
   logic [11:0] bcd;
   logic [11:0] bcd_adj;
   logic [2:0]  iter;
   logic [6:0]  last;
   logic [3:0]  units, tens, hundreds;

   logic [DIV_W-1:0] div;
   logic [1:0]       idx;

   logic [6:0] seg_d;
   logic [2:0] an_d;

   // active-low 7-segment code for one decimal digit
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLK;
      endcase
      return s;
   endfunction

   // add-3 correction on every nibble that would overflow past 9 after the shift
   always_comb begin
      bcd_adj = bcd;
      for (int n = 0; n < 3; n++) begin
         if (bcd[n*4 +: 4] >= 4'd5)
            bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   // next-state: start on a changed input, 7 shift iterations, one load cycle
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (number != last) state_n = CONV;
         CONV:    if (iter == 3'd6)   state_n = LOAD;
         LOAD:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // conversion datapath and display registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap      <= '0;
         shreg    <= '0;
         bcd      <= '0;
         iter     <= '0;
         last     <= '0;
         units    <= '0;
         tens     <= '0;
         hundreds <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (number != last) begin
                  cap   <= number;
                  shreg <= number;
                  bcd   <= '0;
                  iter  <= '0;
               end
            end
            CONV: begin
               bcd   <= {bcd_adj[10:0], shreg[6]};
               shreg <= {shreg[5:0], 1'b0};
               iter  <= iter + 3'd1;
            end
            LOAD: begin
               hundreds <= bcd[11:8];
               tens     <= bcd[7:4];
               units    <= bcd[3:0];
               last     <= cap;
               err      <= (32'(cap) > 32'(MAX_VAL));
            end
            default: ;
         endcase
      end
   end

   // scan divider: each digit slot lasts SCAN_DIV cycles, slots rotate 0->1->2->0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div <= '0;
         idx <= '0;
      end else if (div == DIV_W'(SCAN_DIV - 1)) begin
         div <= '0;
         idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   // digit selection with leading-zero blanking; over-range lights dashes everywhere
   always_comb begin
      seg_d = SEG_BLK;
      an_d  = 3'b111;
      case (idx)
         2'd0: begin
            an_d  = 3'b110;
            seg_d = err ? SEG_DASH : seg7(units);
         end
         2'd1: begin
            if (err) begin
               an_d  = 3'b101;
               seg_d = SEG_DASH;
            end else if (hundreds != 4'd0 || tens != 4'd0) begin
               an_d  = 3'b101;
               seg_d = seg7(tens);
            end
         end
         2'd2: begin
            if (err) begin
               an_d  = 3'b011;
               seg_d = SEG_DASH;
            end else if (hundreds != 4'd0) begin
               an_d  = 3'b011;
               seg_d = seg7(hundreds);
            end
         end
         default: ;
      endcase
   end

   // registered pin drivers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg <= SEG_BLK;
         an  <= 3'b111;
      end else begin
         seg <= seg_d;
         an  <= an_d;
      end
   end

endmodule
